// File: rtl/dbg_gpr_initiator_if.sv
// Debug command/response channel, GPR debug port and core write-port snoop
// for dbg_gpr_initiator. Signal suffixes are relative to the initiator.
interface dbg_gpr_initiator_if #(
    parameter int unsigned LenW = 5
);
    logic            cmd_valid_i;
    logic            cmd_ready_o;
    logic            cmd_write_i;
    logic [4:0]      cmd_addr_i;
    logic [31:0]     cmd_wdata_i;
    logic [LenW-1:0] cmd_len_i;
    logic            cmd_verify_i;
    logic            rsp_valid_o;
    logic            rsp_ready_i;
    logic [31:0]     rsp_rdata_o;
    logic            rsp_err_o;
    logic            rsp_last_o;
    logic            jtag_we_o;
    logic [4:0]      jtag_addr_o;
    logic [31:0]     jtag_data_o;
    logic [31:0]     jtag_data_i;
    logic            core_we_i;
    logic [4:0]      core_waddr_i;

    modport master (
        input  cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, cmd_len_i, cmd_verify_i,
               rsp_ready_i, jtag_data_i, core_we_i, core_waddr_i,
        output cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_last_o,
               jtag_we_o, jtag_addr_o, jtag_data_o
    );

    modport slave (
        output cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, cmd_len_i, cmd_verify_i,
               rsp_ready_i, jtag_data_i, core_we_i, core_waddr_i,
        input  cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_last_o,
               jtag_we_o, jtag_addr_o, jtag_data_o
    );
endinterface

// File: rtl/dbg_gpr_initiator.sv
// Sequences debug read bursts / single writes onto the GPR debug port,
// retrying writes lost to core ex-stage writes and optionally verifying them.
module dbg_gpr_initiator #(
    parameter int unsigned MaxRetry = 4,
    parameter int unsigned LenW     = 5
) (
    input  logic                clk_i,
    input  logic                rst_i,
    dbg_gpr_initiator_if.master bus
);
    localparam int unsigned DataW  = 32;
    localparam int unsigned AddrW  = 5;
    localparam int unsigned RetryW = (MaxRetry > 1) ? $clog2(MaxRetry) : 1;
    localparam logic [RetryW-1:0] RetryLast = RetryW'(MaxRetry - 1);

    typedef enum logic [2:0] {IDLE, RD, WR, VFY, RSP} state_e;

    state_e            state_q, state_d;
    logic              write_q, write_d;
    logic              verify_q, verify_d;
    logic [AddrW-1:0]  addr_q, addr_d;
    logic [DataW-1:0]  wdata_q, wdata_d;
    logic [LenW-1:0]   len_q, len_d;
    logic [LenW-1:0]   beat_q, beat_d;
    logic [RetryW-1:0] retry_q, retry_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DataW-1:0]  rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic              rsp_last_q, rsp_last_d;
    logic              jtag_we_q, jtag_we_d;
    logic [AddrW-1:0]  jtag_addr_q, jtag_addr_d;
    logic [DataW-1:0]  jtag_data_q, jtag_data_d;
    logic              collision;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            write_q     <= 1'b0;
            verify_q    <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            len_q       <= '0;
            beat_q      <= '0;
            retry_q     <= '0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_last_q  <= 1'b0;
            jtag_we_q   <= 1'b0;
            jtag_addr_q <= '0;
            jtag_data_q <= '0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            verify_q    <= verify_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            len_q       <= len_d;
            beat_q      <= beat_d;
            retry_q     <= retry_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            rsp_last_q  <= rsp_last_d;
            jtag_we_q   <= jtag_we_d;
            jtag_addr_q <= jtag_addr_d;
            jtag_data_q <= jtag_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        verify_d    = verify_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        len_d       = len_q;
        beat_d      = beat_q;
        retry_d     = retry_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        rsp_last_d  = rsp_last_q;
        // The core wins the regs write port, so any core write loses ours.
        collision   = bus.core_we_i && (bus.core_waddr_i != '0);

        unique case (state_q)
            IDLE: begin
                if (bus.cmd_valid_i) begin
                    write_d  = bus.cmd_write_i;
                    verify_d = bus.cmd_verify_i;
                    addr_d   = bus.cmd_addr_i;
                    wdata_d  = bus.cmd_wdata_i;
                    len_d    = bus.cmd_len_i;
                    beat_d   = '0;
                    retry_d  = '0;
                    state_d  = bus.cmd_write_i ? WR : RD;
                end
            end
            RD: begin
                rsp_rdata_d = (addr_q == '0) ? '0 : bus.jtag_data_i;
                rsp_err_d   = 1'b0;
                rsp_last_d  = (beat_q == len_q);
                rsp_valid_d = 1'b1;
                state_d     = RSP;
            end
            WR: begin
                if (addr_q != '0 && collision && retry_q < RetryLast) begin
                    retry_d = retry_q + RetryW'(1);
                end else if (addr_q != '0 && !collision && verify_q) begin
                    state_d = VFY;
                end else begin
                    rsp_rdata_d = wdata_q;
                    rsp_err_d   = (addr_q != '0) && collision;
                    rsp_last_d  = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = RSP;
                end
            end
            VFY: begin
                rsp_rdata_d = wdata_q;
                rsp_err_d   = (bus.jtag_data_i != wdata_q);
                rsp_last_d  = 1'b1;
                rsp_valid_d = 1'b1;
                state_d     = RSP;
            end
            RSP: begin
                if (bus.rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    if (!write_q && beat_q < len_q) begin
                        beat_d  = beat_q + LenW'(1);
                        addr_d  = addr_q + AddrW'(1);
                        state_d = RD;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Port drives are registered, so derive them from the next state.
        cmd_ready_d = (state_d == IDLE);
        jtag_we_d   = (state_d == WR) && (addr_d != '0);
        jtag_addr_d = (state_d inside {RD, WR, VFY}) ? addr_d : '0;
        jtag_data_d = (state_d == WR) ? wdata_d : '0;
    end

    assign bus.cmd_ready_o = cmd_ready_q;
    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.rsp_rdata_o = rsp_rdata_q;
    assign bus.rsp_err_o   = rsp_err_q;
    assign bus.rsp_last_o  = rsp_last_q;
    assign bus.jtag_we_o   = jtag_we_q;
    assign bus.jtag_addr_o = jtag_addr_q;
    assign bus.jtag_data_o = jtag_data_q;
endmodule

// File: tb/tb_dbg_gpr_initiator.sv
// Bench for dbg_gpr_initiator: directed vector table, hand-written corner
// sequences and random commands against a GPR-file reference model.
module tb_dbg_gpr_initiator;
    localparam int unsigned MaxRetry = 4;

    typedef struct {
        logic        write;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic        verify;
        int          core_k;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_pulses;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dbg_gpr_initiator_if #(.LenW(5)) bif ();

    dbg_gpr_initiator #(.MaxRetry(MaxRetry), .LenW(5)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bif)
    );

    // Register file stand-in: core port has priority, x0 returns junk so the
    // initiator has to produce the zero itself.
    logic [31:0] gpr [32];
    logic [31:0] core_wdata = '0;
    logic        drop_jtag  = 1'b0;
    int          we_cnt     = 0;
    int          we_x0      = 0;

    assign bif.jtag_data_i = (bif.jtag_addr_o == 5'd0) ? 32'hBAD0_0BAD : gpr[bif.jtag_addr_o];

    always @(posedge clk) begin
        if (bif.core_we_i && bif.core_waddr_i != 5'd0) gpr[bif.core_waddr_i] <= core_wdata;
        else if (bif.jtag_we_o && bif.jtag_addr_o != 5'd0 && !drop_jtag)
            gpr[bif.jtag_addr_o] <= bif.jtag_data_o;
        if (bif.jtag_we_o) we_cnt <= we_cnt + 1;
        if (bif.jtag_we_o && bif.jtag_addr_o == 5'd0) we_x0 <= we_x0 + 1;
    end

    int          checks = 0;
    int          errors = 0;
    logic [31:0] ref_mem [32];
    logic [31:0] got_rdata [$];
    logic        got_err [$];
    logic        got_last [$];
    int          got_lat;
    int          got_pulses;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [4:0] a, input logic [31:0] d);
        bif.core_we_i    = 1'b1;
        bif.core_waddr_i = a;
        core_wdata       = d;
        if (a != 5'd0) ref_mem[a] = d;
        tick();
        bif.core_we_i = 1'b0;
    endtask

    // Issue one command, run core traffic for the first k cycles after accept,
    // and collect every response beat.
    task automatic run_cmd(input logic wr, input logic [4:0] addr, input logic [31:0] wdata,
                           input logic [4:0] len, input logic verify, input int k,
                           input logic [4:0] caddr, input logic [31:0] cdata, input int ready_pct);
        int cyc;
        int we_start;
        bit first;
        bit done;
        got_rdata.delete();
        got_err.delete();
        got_last.delete();
        got_lat = -1;
        cyc = 0;
        while (!bif.cmd_ready_o && cyc < 50) begin
            tick();
            cyc++;
        end
        check("cmd_ready", 32'(bif.cmd_ready_o), 32'd1);
        we_start         = we_cnt;
        bif.cmd_valid_i  = 1'b1;
        bif.cmd_write_i  = wr;
        bif.cmd_addr_i   = addr;
        bif.cmd_wdata_i  = wdata;
        bif.cmd_len_i    = len;
        bif.cmd_verify_i = verify;
        bif.core_waddr_i = caddr;
        core_wdata       = cdata;
        tick();
        bif.cmd_valid_i = 1'b0;
        first = 1'b1;
        done  = 1'b0;
        cyc   = 1;
        while (!done && cyc < 400) begin
            bif.core_we_i = (cyc <= k);
            if (bif.rsp_valid_o) begin
                if (first) begin
                    got_lat = cyc;
                    first   = 1'b0;
                end
                bif.rsp_ready_i = ($urandom_range(99) < ready_pct);
                if (bif.rsp_ready_i) begin
                    got_rdata.push_back(bif.rsp_rdata_o);
                    got_err.push_back(bif.rsp_err_o);
                    got_last.push_back(bif.rsp_last_o);
                    if (bif.rsp_last_o) done = 1'b1;
                end
            end else begin
                bif.rsp_ready_i = 1'b0;
            end
            tick();
            cyc++;
        end
        bif.rsp_ready_i = 1'b0;
        bif.core_we_i   = 1'b0;
        got_pulses      = we_cnt - we_start;
        check("rsp_done", 32'(done), 32'd1);
    endtask

    // Write outcome from the retry rules: attempt n collides while the core is
    // still busy (n <= k); the write lands on attempt k+1 if that is within budget.
    task automatic model_write(input logic [4:0] addr, input logic [31:0] wdata, input logic verify,
                               input int k, input logic [4:0] caddr, input logic [31:0] cdata,
                               output logic exp_err, output int exp_lat, output int exp_pulses);
        int attempts;
        bit ok;
        if (k > 0) ref_mem[caddr] = cdata;
        if (addr == 5'd0) begin
            exp_err    = 1'b0;
            exp_lat    = 2;
            exp_pulses = 0;
        end else begin
            ok         = (k < int'(MaxRetry));
            attempts   = ok ? k + 1 : int'(MaxRetry);
            exp_pulses = attempts;
            exp_err    = !ok;
            exp_lat    = attempts + 1 + ((ok && verify) ? 1 : 0);
            if (ok) ref_mem[addr] = wdata;
        end
    endtask

    task automatic compare_beats(input string tag, input logic [31:0] exp_rd [$],
                                 input logic exp_err, input int exp_lat, input int exp_pulses);
        int n;
        check({tag, "_beats"}, 32'(got_rdata.size()), 32'(exp_rd.size()));
        n = (got_rdata.size() < exp_rd.size()) ? got_rdata.size() : exp_rd.size();
        for (int b = 0; b < n; b++) begin
            check({tag, "_rdata"}, got_rdata[b], exp_rd[b]);
            check({tag, "_err"}, 32'(got_err[b]), 32'(exp_err));
            check({tag, "_last"}, 32'(got_last[b]), 32'(b == exp_rd.size() - 1));
        end
        check({tag, "_lat"}, 32'(got_lat), 32'(exp_lat));
        check({tag, "_pulses"}, 32'(got_pulses), 32'(exp_pulses));
    endtask

    initial begin
        vec_t        vecs [9];
        logic [31:0] exp_rd [$];
        logic [31:0] burst_exp [4];
        logic        e_err;
        int          e_lat;
        int          e_pul;

        vecs[0] = '{1'b0, 5'd5, 32'h0,         1'b0, 0, 32'hDEADBEEF, 1'b0, 2, 0};
        vecs[1] = '{1'b1, 5'd7, 32'h12345678,  1'b1, 0, 32'h12345678, 1'b0, 3, 1};
        vecs[2] = '{1'b0, 5'd7, 32'h0,         1'b0, 0, 32'h12345678, 1'b0, 2, 0};
        vecs[3] = '{1'b1, 5'd7, 32'hA5A5A5A5,  1'b0, 2, 32'hA5A5A5A5, 1'b0, 4, 3};
        vecs[4] = '{1'b1, 5'd7, 32'h0BADF00D,  1'b0, 4, 32'h0BADF00D, 1'b1, 5, 4};
        vecs[5] = '{1'b0, 5'd7, 32'h0,         1'b0, 0, 32'hA5A5A5A5, 1'b0, 2, 0};
        vecs[6] = '{1'b1, 5'd0, 32'hFFFFFFFF,  1'b1, 0, 32'hFFFFFFFF, 1'b0, 2, 0};
        vecs[7] = '{1'b0, 5'd0, 32'h0,         1'b0, 0, 32'h00000000, 1'b0, 2, 0};
        vecs[8] = '{1'b1, 5'd9, 32'hCAFEF00D,  1'b1, 3, 32'hCAFEF00D, 1'b0, 6, 4};

        bif.cmd_valid_i  = 1'b0;
        bif.cmd_write_i  = 1'b0;
        bif.cmd_addr_i   = '0;
        bif.cmd_wdata_i  = '0;
        bif.cmd_len_i    = '0;
        bif.cmd_verify_i = 1'b0;
        bif.rsp_ready_i  = 1'b0;
        bif.core_we_i    = 1'b0;
        bif.core_waddr_i = '0;
        ref_mem[0]       = '0;

        repeat (2) tick();
        check("rst_cmd_ready", 32'(bif.cmd_ready_o), 32'd1);
        check("rst_rsp_valid", 32'(bif.rsp_valid_o), 32'd0);
        check("rst_rsp_rdata", bif.rsp_rdata_o, 32'd0);
        check("rst_jtag_we", 32'(bif.jtag_we_o), 32'd0);
        check("rst_jtag_addr", 32'(bif.jtag_addr_o), 32'd0);
        rst = 1'b0;

        for (int a = 1; a < 32; a++) preload(5'(a), $urandom);
        preload(5'd5, 32'hDEADBEEF);

        // Directed vector table (core traffic targets x3).
        for (int i = 0; i < 9; i++) begin
            run_cmd(vecs[i].write, vecs[i].addr, vecs[i].wdata, 5'd0, vecs[i].verify,
                    vecs[i].core_k, 5'd3, 32'h3333_0000 + 32'(i), 100);
            if (vecs[i].write)
                model_write(vecs[i].addr, vecs[i].wdata, vecs[i].verify, vecs[i].core_k,
                            5'd3, 32'h3333_0000 + 32'(i), e_err, e_lat, e_pul);
            exp_rd.delete();
            exp_rd.push_back(vecs[i].exp_rdata);
            compare_beats($sformatf("vec%0d", i), exp_rd, vecs[i].exp_err,
                          vecs[i].exp_lat, vecs[i].exp_pulses);
        end

        // Burst across the 31->0 wrap with a stalled second beat.
        burst_exp[0] = 32'hAAAA_0001;
        burst_exp[1] = 32'hBBBB_0002;
        burst_exp[2] = 32'h0;
        burst_exp[3] = 32'hDDDD_0004;
        preload(5'd30, burst_exp[0]);
        preload(5'd31, burst_exp[1]);
        preload(5'd1, burst_exp[3]);
        bif.cmd_valid_i = 1'b1;
        bif.cmd_write_i = 1'b0;
        bif.cmd_addr_i  = 5'd30;
        bif.cmd_len_i   = 5'd3;
        tick();
        bif.cmd_valid_i = 1'b0;
        for (int b = 0; b < 4; b++) begin
            for (int c = 0; c < 20 && !bif.rsp_valid_o; c++) tick();
            check("burst_valid", 32'(bif.rsp_valid_o), 32'd1);
            if (b == 1) begin
                for (int h = 0; h < 5; h++) begin
                    check("burst_hold", bif.rsp_rdata_o, burst_exp[1]);
                    tick();
                end
            end
            check("burst_rdata", bif.rsp_rdata_o, burst_exp[b]);
            check("burst_last", 32'(bif.rsp_last_o), 32'(b == 3));
            bif.rsp_ready_i = 1'b1;
            tick();
            bif.rsp_ready_i = 1'b0;
        end

        // Verify catches a write the regs silently dropped.
        preload(5'd9, 32'h1111_1111);
        drop_jtag = 1'b1;
        run_cmd(1'b1, 5'd9, 32'h2222_2222, 5'd0, 1'b1, 0, 5'd3, 32'h0, 100);
        drop_jtag = 1'b0;
        exp_rd.delete();
        exp_rd.push_back(32'h2222_2222);
        compare_beats("vfy_mismatch", exp_rd, 1'b1, 3, 1);

        // Reset while a write is retrying behind core traffic.
        bif.cmd_valid_i  = 1'b1;
        bif.cmd_write_i  = 1'b1;
        bif.cmd_addr_i   = 5'd7;
        bif.cmd_wdata_i  = 32'h7777_7777;
        bif.cmd_verify_i = 1'b0;
        bif.core_waddr_i = 5'd3;
        core_wdata       = 32'h3030_3030;
        tick();
        bif.cmd_valid_i = 1'b0;
        bif.core_we_i   = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        check("rst_mid_cmd_ready", 32'(bif.cmd_ready_o), 32'd1);
        check("rst_mid_rsp_valid", 32'(bif.rsp_valid_o), 32'd0);
        check("rst_mid_jtag_we", 32'(bif.jtag_we_o), 32'd0);
        rst           = 1'b0;
        bif.core_we_i = 1'b0;
        ref_mem[3]    = 32'h3030_3030;
        tick();
        run_cmd(1'b0, 5'd7, 32'h0, 5'd0, 1'b0, 0, 5'd3, 32'h0, 100);
        exp_rd.delete();
        exp_rd.push_back(ref_mem[7]);
        compare_beats("rst_mid_x7", exp_rd, 1'b0, 2, 0);

        // Random commands with random back-pressure.
        for (int i = 0; i < 60; i++) begin
            logic        wr;
            logic        vf;
            logic [4:0]  ad;
            logic [4:0]  ln;
            logic [4:0]  ca;
            logic [31:0] wd;
            logic [31:0] cd;
            int          k;
            wr = 1'($urandom_range(1));
            vf = 1'($urandom_range(1));
            ad = (i % 10 == 0) ? 5'd0 : 5'($urandom_range(31));
            ln = wr ? 5'd0 : 5'($urandom_range(7));
            ca = 5'($urandom_range(31, 1));
            wd = $urandom;
            cd = $urandom;
            k  = wr ? int'($urandom_range(MaxRetry)) : 0;
            run_cmd(wr, ad, wd, ln, vf, k, ca, cd, 70);
            exp_rd.delete();
            if (wr) begin
                model_write(ad, wd, vf, k, ca, cd, e_err, e_lat, e_pul);
                exp_rd.push_back(wd);
            end else begin
                for (int b = 0; b <= int'(ln); b++) begin
                    logic [4:0] a;
                    a = 5'((int'(ad) + b) % 32);
                    exp_rd.push_back((a == 5'd0) ? 32'h0 : ref_mem[a]);
                end
                e_err = 1'b0;
                e_lat = 2;
                e_pul = 0;
            end
            compare_beats($sformatf("rnd%0d", i), exp_rd, e_err, e_lat, e_pul);
        end

        check("we_to_x0", 32'(we_x0), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
